// File: rtl/cart_rom_rd.sv
// Cartridge ROM read sequencer: SETUP/ACCESS/HOLD strobe timing on a shared cartridge bus.
// Define CART_RD_CACHE_EN to add a one-entry read cache that answers repeat addresses without a bus cycle.
module cart_rom_rd #(
    parameter int SETUP_CYC  = 2,
    parameter int ACCESS_CYC = 6,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic        bus_en,
    input  logic [15:0] rom_addr,
    input  logic        rom_rd,
    output logic [7:0]  rom_data,
    output logic        rom_bsy,
    output logic [15:0] cart_a,
    input  logic [7:0]  cart_d,
    output logic        cart_nrd,
    output logic        cart_oe
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    logic [1:0] state_r;
    logic [3:0] cnt_r;
    logic       rd_q_r;
    logic       accept_s;
    logic       capture_s;
    logic       hit_s;

`ifdef CART_RD_CACHE_EN
    logic [15:0] cache_tag_r;
    logic [7:0]  cache_data_r;
    logic        cache_valid_r;
`endif

    // Request acceptance, capture strobe and cache hit decode.
    always_comb begin
        accept_s  = 1'b0;
        capture_s = 1'b0;
        hit_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = cart_oe & rom_rd & ~rd_q_r;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ST_ACCESS) && (cnt_r == 4'd0)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
`ifdef CART_RD_CACHE_EN
        if (cache_valid_r && (cache_tag_r == rom_addr)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
`endif
    end

    // Main read sequencer with registered bus and host outputs.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            rd_q_r   <= 1'b1;
            rom_bsy  <= 1'b0;
            cart_nrd <= 1'b1;
            cart_a   <= 16'h0000;
            rom_data <= 8'h00;
            cart_oe  <= 1'b0;
        end else begin
            rd_q_r  <= rom_rd;
            cart_oe <= bus_en;
            case (state_r)
                ST_IDLE: begin
                    rom_bsy <= 1'b0;
                    if (accept_s) begin
                        cart_a  <= rom_addr;
                        rom_bsy <= 1'b1;
                        if (hit_s) begin
`ifdef CART_RD_CACHE_EN
                            rom_data <= cache_data_r;
`endif
                        end else begin
                            state_r <= ST_SETUP;
                            cnt_r   <= SETUP_LD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= ST_ACCESS;
                        cnt_r    <= ACCESS_LD;
                        cart_nrd <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (capture_s) begin
                        state_r  <= ST_HOLD;
                        cnt_r    <= HOLD_LD;
                        cart_nrd <= 1'b1;
                        rom_data <= cart_d;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        rom_bsy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 4'd0;
                    rom_bsy  <= 1'b0;
                    cart_nrd <= 1'b1;
                end
            endcase
        end
    end

`ifdef CART_RD_CACHE_EN
    // One-entry cache; dropping bus ownership invalidates it since the cartridge may change.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            cache_tag_r   <= 16'h0000;
            cache_data_r  <= 8'h00;
            cache_valid_r <= 1'b0;
        end else if (!bus_en) begin
            cache_valid_r <= 1'b0;
        end else if (capture_s) begin
            cache_tag_r   <= cart_a;
            cache_data_r  <= cart_d;
            cache_valid_r <= 1'b1;
        end else begin
            cache_valid_r <= cache_valid_r;
        end
    end
`endif

endmodule

// File: tb/tb_cart_rom_rd.sv
// Directed-vector bench for cart_rom_rd; a negedge monitor pops expected transactions when rom_bsy falls.
`timescale 1ns/100ps
module tb_cart_rom_rd;

    logic        clk_8m = 1'b0;
    logic        rst = 1'b1;
    logic        bus_en = 1'b0;
    logic [15:0] rom_addr = 16'h0000;
    logic        rom_rd = 1'b0;
    logic [7:0]  rom_data;
    logic        rom_bsy;
    logic [15:0] cart_a;
    logic [7:0]  cart_d = 8'h00;
    logic        cart_nrd;
    logic        cart_oe;

    cart_rom_rd dut (
        .clk_8m(clk_8m), .rst(rst), .bus_en(bus_en), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .rom_data(rom_data), .rom_bsy(rom_bsy), .cart_a(cart_a),
        .cart_d(cart_d), .cart_nrd(cart_nrd), .cart_oe(cart_oe)
    );

    always #62.5 clk_8m = ~clk_8m;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
        int          nrd;
        int          first;
        int          pulses;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d, input int len,
                        input int nrd, input int first, input int pulses);
        exp_t e;
        e.addr = a; e.data = d; e.len = len; e.nrd = nrd; e.first = first; e.pulses = pulses;
        exp_q.push_back(e);
    endtask

    task automatic push_full(input logic [15:0] a, input logic [7:0] d);
        push(a, d, 9, 6, 3, 1);
    endtask

    task automatic cyc();
        @(posedge clk_8m);
        #1;
    endtask

    // Monitor: measures each busy window and compares it with the next expected transaction.
    int  bsy_len = 0, nrd_cnt = 0, nrd_first = 0, nrd_pulses = 0, stray = 0;
    logic bsy_prev = 1'b0, nrd_prev = 1'b1, rst_prev = 1'b0;
    always @(negedge clk_8m) begin
        if (rst) begin
            bsy_len = 0; nrd_cnt = 0; nrd_first = 0; nrd_pulses = 0;
        end else if (rom_bsy) begin
            bsy_len++;
            if (!cart_nrd) begin
                nrd_cnt++;
                if (nrd_first == 0) nrd_first = bsy_len;
                if (nrd_prev) nrd_pulses++;
            end
        end else begin
            if (!cart_nrd) stray++;
            if (bsy_prev && !rst_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("txn_bsy_len", bsy_len, e.len);
                    chk("txn_nrd_cycles", nrd_cnt, e.nrd);
                    chk("txn_nrd_first", nrd_first, e.first);
                    chk("txn_nrd_pulses", nrd_pulses, e.pulses);
                    chk("txn_rom_data", {24'd0, rom_data}, {24'd0, e.data});
                    chk("txn_cart_a", {16'd0, cart_a}, {16'd0, e.addr});
                end
            end
            bsy_len = 0; nrd_cnt = 0; nrd_first = 0; nrd_pulses = 0;
        end
        bsy_prev = rom_bsy;
        nrd_prev = cart_nrd;
        rst_prev = rst;
    end

    int act_flag;

    initial begin
        // Reset state
        repeat (3) cyc();
        @(negedge clk_8m);
        chk("rst_nrd", cart_nrd, 1'b1);
        chk("rst_bsy", rom_bsy, 1'b0);
        chk("rst_cart_a", cart_a, 16'h0000);
        chk("rst_rom_data", rom_data, 8'h00);
        chk("rst_cart_oe", cart_oe, 1'b0);
        cyc();
        rst = 1'b0; bus_en = 1'b1;
        repeat (2) cyc();
        @(negedge clk_8m);
        chk("oe_follows_bus_en", cart_oe, 1'b1);

        // Single read 0x0134 -> 0xA5, strobe window T+3..T+8
        cyc();
        rom_addr = 16'h0134; cart_d = 8'hA5; rom_rd = 1'b1;
        push_full(16'h0134, 8'hA5);
        cyc(); rom_rd = 1'b0;
        cyc(); @(negedge clk_8m); chk("t1_nrd_T2", cart_nrd, 1'b1);
        cyc(); @(negedge clk_8m); chk("t1_nrd_T3", cart_nrd, 1'b0);
        repeat (6) cyc();
        @(negedge clk_8m);
        chk("t1_bsy_T9", rom_bsy, 1'b1);
        chk("t1_nrd_T9", cart_nrd, 1'b1);
        cyc(); @(negedge clk_8m);
        chk("t1_bsy_T10", rom_bsy, 1'b0);
        repeat (2) cyc();

        // Second edge at T+4 is ignored; address change mid-read must not reach cart_a
        rom_addr = 16'h0200; cart_d = 8'h3C; rom_rd = 1'b1;
        push_full(16'h0200, 8'h3C);
        cyc(); rom_rd = 1'b0;
        repeat (3) cyc();
        rom_rd = 1'b1; rom_addr = 16'h0999;
        cyc(); rom_rd = 1'b0;
        repeat (4) cyc();
        @(negedge clk_8m); chk("t2_bsy_T9", rom_bsy, 1'b1);
        cyc(); @(negedge clk_8m); chk("t2_bsy_T10", rom_bsy, 1'b0);
        repeat (2) cyc();

        // Reset inside ACCESS at T+5, rom_rd held high afterwards
        rom_addr = 16'h0300; cart_d = 8'h77; rom_rd = 1'b1;
        repeat (5) cyc();
        rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk_8m);
        chk("t3_nrd_after_rst", cart_nrd, 1'b1);
        chk("t3_bsy_after_rst", rom_bsy, 1'b0);
        chk("t3_data_after_rst", rom_data, 8'h00);
        chk("t3_cart_a_after_rst", cart_a, 16'h0000);
        act_flag = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk_8m);
            if (rom_bsy || !cart_nrd) act_flag = 1;
        end
        chk("t3_held_rd_no_read", act_flag, 0);
        rom_rd = 1'b0;
        cyc();

        // bus_en low: edge ignored; then bus_en high and a fresh edge one cycle later
        bus_en = 1'b0;
        repeat (2) cyc();
        rom_addr = 16'h0400; cart_d = 8'h5A; rom_rd = 1'b1;
        act_flag = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); @(negedge clk_8m);
            if (rom_bsy || !cart_nrd) act_flag = 1;
        end
        chk("t4_no_activity_bus_off", act_flag, 0);
        chk("t4_cart_oe_low", cart_oe, 1'b0);
        rom_rd = 1'b0;
        cyc();
        bus_en = 1'b1;
        cyc();
        rom_rd = 1'b1;
        push_full(16'h0400, 8'h5A);
        cyc(); rom_rd = 1'b0;
        repeat (12) cyc();

        // Back-to-back: second edge in the first IDLE cycle (T+10)
        rom_addr = 16'h0100; cart_d = 8'h11; rom_rd = 1'b1;
        push_full(16'h0100, 8'h11);
        cyc(); rom_rd = 1'b0;
        repeat (9) cyc();
        rom_addr = 16'h0101; cart_d = 8'h22; rom_rd = 1'b1;
        push_full(16'h0101, 8'h22);
        @(negedge clk_8m); chk("t5_idle_gap_T10", rom_bsy, 1'b0);
        cyc(); rom_rd = 1'b0;
        @(negedge clk_8m); chk("t5_second_bsy_T11", rom_bsy, 1'b1);
        repeat (12) cyc();

        // Repeat read of 0x0147
        rom_addr = 16'h0147; cart_d = 8'h99; rom_rd = 1'b1;
        push_full(16'h0147, 8'h99);
        cyc(); rom_rd = 1'b0;
        repeat (12) cyc();
        rom_rd = 1'b1;
`ifdef CART_RD_CACHE_EN
        cart_d = 8'hEE;
        push(16'h0147, 8'h99, 1, 0, 0, 0);
`else
        push_full(16'h0147, 8'h99);
`endif
        cyc(); rom_rd = 1'b0;
        repeat (12) cyc();

        @(negedge clk_8m);
        chk("pending_txns", exp_q.size(), 0);
        chk("stray_nrd_cycles", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_rom_rd.md
CART_ROM_RD -- requirements
Module: cart_rom_rd

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles address is driven before cart_nrd falls (legal range 1..15).
REQ-002 SHALL have parameter ACCESS_CYC, default 6, cycles cart_nrd is held low, 750 ns at 8 MHz (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, cycles address is held after cart_nrd rises (legal range 1..15).
REQ-004 SHALL have port clk_8m  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port bus_en  in  1  permission to own the cartridge bus.
REQ-007 SHALL have port rom_addr  in  16  requested ROM byte address.
REQ-008 SHALL have port rom_rd  in  1  read request; its rising edge starts a read.
REQ-009 SHALL have port rom_data  out  8  returned byte, registered.
REQ-010 SHALL have port rom_bsy  out  1  high while a read is in progress.
REQ-011 SHALL have port cart_a  out  16  cartridge address bus.
REQ-012 SHALL have port cart_d  in  8  cartridge data bus.
REQ-013 SHALL have port cart_nrd  out  1  cartridge read strobe, active-low.
REQ-014 SHALL have port cart_oe  out  1  enables this block's cartridge bus drivers; equals bus_en registered.

Function
REQ-015 SHALL keep a registered copy rd_q of rom_rd; request edge = rom_rd & ~rd_q.
REQ-016 SHALL accept a request only in IDLE with cart_oe=1 and a request edge in the same cycle T; it latches rom_addr into cart_a at the T edge.
REQ-017 SHALL ignore edges seen while not IDLE or while cart_oe=0: no queueing, no later replay; a level held high never retriggers.
REQ-018 SHALL use states IDLE -> SETUP -> ACCESS -> HOLD -> IDLE, with a 4-bit down-counter loaded on each entry.
REQ-019 SHALL stay in SETUP for cycles T+1..T+SETUP_CYC with cart_nrd=1.
REQ-020 SHALL stay in ACCESS for the next ACCESS_CYC cycles with cart_nrd=0.
REQ-021 SHALL capture cart_d into rom_data on the clock edge that ends the last ACCESS cycle.
REQ-022 SHALL stay in HOLD for HOLD_CYC cycles with cart_nrd=1 and cart_a unchanged.
REQ-023 SHALL drive rom_bsy=1 from cycle T+1 through the last HOLD cycle: SETUP_CYC+ACCESS_CYC+HOLD_CYC cycles total, 9 at defaults; rom_data is valid and stable when rom_bsy falls.
REQ-024 SHALL leave rom_data and cart_a unchanged outside a capture edge or accept edge.
REQ-025 SHALL let a read in progress complete normally if bus_en falls mid-read, with cart_oe following bus_en one cycle later.
REQ-026 SHALL accept a new request edge in the first IDLE cycle after HOLD, giving back-to-back reads.

Reset
REQ-027 SHALL, on a cycle with rst=1, override everything and set state=IDLE, rom_bsy=0, cart_nrd=1, cart_a=0x0000, rom_data=0x00, cart_oe=0, rd_q=1 and counter=0.
REQ-028 SHALL abort a read in progress immediately on reset: cart_nrd=1 on the next cycle, no capture, no rom_bsy completion pulse.
REQ-029 SHALL not start a read after reset until rom_rd is seen low and then high (rd_q=1 blocks a held-high rom_rd).

Configuration
REQ-030 SHALL, with macro CART_RD_CACHE_EN defined, hold a one-entry cache: tag (16 bits), data (8 bits) and valid, written on each capture.
REQ-031 SHALL, with CART_RD_CACHE_EN defined, answer an accepted request whose rom_addr equals the tag with valid=1 without any cart cycle: rom_bsy=1 only at T+1, rom_data=cached byte at T+1, cart_nrd stays 1, and cart_a still updates.
REQ-032 SHALL, with CART_RD_CACHE_EN defined, clear valid on reset and on any cycle with bus_en=0.
REQ-033 SHALL, with CART_RD_CACHE_EN undefined, contain no cache logic, so every accepted request performs the full cycle.

Verification
REQ-034 SHALL cover single read at defaults: cart_d=0xA5 for rom_addr=0x0134 -> rom_bsy high 9 cycles, cart_nrd low in cycles T+3..T+8, cart_a=0x0134, rom_data=0xA5 when rom_bsy falls.
REQ-035 SHALL cover a second rom_rd edge at T+4 during a read -> ignored, exactly one cart_nrd low pulse, rom_bsy low at T+10.
REQ-036 SHALL cover rst=1 at cycle T+5 (inside ACCESS) -> next cycle cart_nrd=1, rom_bsy=0, rom_data=0x00; rom_rd still high after reset causes no read.
REQ-037 SHALL cover bus_en=0 then a rom_rd edge -> no rom_bsy and no cart_nrd activity; bus_en=1 followed by a new edge one cycle later -> normal 9-cycle read.
REQ-038 SHALL cover back-to-back reads of 0x0100 and 0x0101 where the second edge lands in the first IDLE cycle -> two 9-cycle reads, 1 idle cycle between them.
REQ-039 SHALL cover, with CART_RD_CACHE_EN defined, reading 0x0147 twice -> second read shows rom_bsy for 1 cycle, no cart_nrd pulse, same data; without the macro -> two 9-cycle reads.
